not_arbiter: RTL

NOT_ARBITER -- requirements
Module: not_arbiter

---
 rtl/not_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/not_arbiter.sv
// ---------------------------------------------------------------------------
// not_arbiter
//   N requesters share a single bitwise-inverter unit. A round-robin
//   arbiter picks one pending requester in IDLE and latches its operand.
//   EXEC drives the inverted operand and a one-cycle ack. DONE waits for the
//   served requester to drop req, which completes a 4-phase handshake.
//
// Parameters
//   N         number of requesters (2..8)
//   W         operand / result width
//
// Ports
//   clk       clock, rising edge active
//   rst_n     synchronous active-low reset
//   req       per-requester request, held until the matching ack
//   data_in   packed operands, requester i on [i*W +: W]
//   ack       one-hot, one-cycle result-valid pulse
//   data_out  registered ~operand of the served requester
//   out_id    index of the requester granted / last served
//   busy      high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module not_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         data_out,
  output logic [$clog2(N)-1:0] out_id,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [IW-1:0] last_q,     last_d;
  logic [IW-1:0] out_id_q,   out_id_d;
  logic [W-1:0]  op_q,       op_d;
  logic [W-1:0]  data_out_q, data_out_d;
  logic [N-1:0]  ack_q,      ack_d;
  logic          busy_q,     busy_d;

  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [W-1:0]  gnt_op;
  int unsigned   cand;

  // Round-robin pick: walk the ring starting just after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(last_q) + 32'd1 + k;
      // last_q <= N-1 and k <= N-1, so one wrap is enough.
      if (cand >= N) cand = cand - N;
      if (!gnt_found && req[cand[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

  // Operand of the requester being granted this cycle.
  always_comb begin
    gnt_op = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_idx == IW'(i)) gnt_op = data_in[i*W +: W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    out_id_d   = out_id_q;
    op_d       = op_q;
    data_out_d = data_out_q;
    ack_d      = '0;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          state_d  = ST_EXEC;
          last_d   = gnt_idx;
          out_id_d = gnt_idx;
          op_d     = gnt_op;
        end
      end
      ST_EXEC: begin
        data_out_d = ~op_q;
        for (int unsigned i = 0; i < N; i++) begin
          ack_d[i] = (out_id_q == IW'(i));
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Hold until the served requester releases its request.
        if (!req[out_id_q]) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= IW'(N - 1);
      out_id_q   <= '0;
      op_q       <= '0;
      data_out_q <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      out_id_q   <= out_id_d;
      op_q       <= op_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign data_out = data_out_q;
  assign out_id   = out_id_q;
  assign busy     = busy_q;

endmodule
